t10_uart_rx: RTL and testbench

UART receive front end: deserializes an asynchronous 8N1 serial line into bytes and presents each completed byte with a one-cycle strobe. It is the receive-side counterpart of the t10 message-register/UART transmit path. Its rx_byte/rx_ready outputs drive the data/ready inputs of a message register, so a byte received here can be looped back out through the transmit chain.

---
 rtl/t10_uart_rx.sv | 191 +++++++++++++++++++
 tb/tb_t10_uart_rx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t10_uart_rx.sv
// -----------------------------------------------------------------------------
// t10_uart_rx
// UART receive front end. Deserializes an asynchronous 8N1 serial line
// (LSB first, 1 start bit, 8 data bits, 1 stop bit) into bytes.
//
// Parameters
//   CLKS_PER_BIT : system clock cycles per serial bit (>= 4)
//
// Ports
//   clk        in   system clock, rising-edge logic
//   nRst       in   asynchronous active-low reset
//   rx_serial  in   asynchronous serial line, idles high
//   rx_byte    out  last correctly framed byte, held between frames
//   rx_ready   out  one-cycle pulse when rx_byte has just been updated
//   frame_err  out  one-cycle pulse when the stop bit was sampled low
//   busy       out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module t10_uart_rx #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF_M1  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Synchronizer flops; both idle high so reset does not look like a start edge.
    logic             sync1_q;
    logic             sync2_q;
    logic             rx_sync;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       bit_idx_q,   bit_idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       rx_byte_q,   rx_byte_d;
    logic             rx_ready_q,  rx_ready_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q,      busy_d;

    assign rx_sync = sync2_q;

    // Two-flop synchronizer for the asynchronous serial input.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_serial;
            sync2_q <= sync1_q;
        end
    end

    // Next-state and datapath logic for the receive FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_ready_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = CNT_ZERO;
                bit_idx_d = 3'd0;
                if (rx_sync == 1'b0) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                // Re-check the line in the middle of the start bit; a high
                // sample means the falling edge was only a glitch.
                if (cnt_q == CNT_HALF_M1) begin
                    cnt_d = CNT_ZERO;
                    if (rx_sync == 1'b0) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DATA: begin
                // Mid-start alignment means each full bit period lands mid-bit.
                if (cnt_q == CNT_BIT_M1) begin
                    cnt_d   = CNT_ZERO;
                    shift_d = {rx_sync, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_STOP: begin
                if (cnt_q == CNT_BIT_M1) begin
                    cnt_d = CNT_ZERO;
                    if (rx_sync == 1'b1) begin
                        rx_byte_d  = shift_q;
                        rx_ready_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_BREAK: begin
                // Wait for the line to recover so a held-low line is not
                // mistaken for a fresh start bit.
                cnt_d = CNT_ZERO;
                if (rx_sync == 1'b1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cnt_d     = CNT_ZERO;
                bit_idx_d = 3'd0;
            end
        endcase

        // Registered from the next state so busy tracks state exactly.
        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_byte_q   <= 8'h00;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_ready_q  <= rx_ready_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_byte   = rx_byte_q;
    assign rx_ready  = rx_ready_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_t10_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_t10_uart_rx
// Self-checking bench for t10_uart_rx with CLKS_PER_BIT = 8. Expected bytes
// are queued as frames are driven and compared when rx_ready pulses.
// -----------------------------------------------------------------------------
module tb_t10_uart_rx;

    localparam int C = 8;

    logic       clk;
    logic       nRst;
    logic       rx_serial;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic       frame_err;
    logic       busy;

    int pass_cnt  = 0;
    int chk_cnt   = 0;
    int cyc       = 0;
    int start_cyc = 0;

    int ready_cnt      = 0;
    int ferr_cnt       = 0;
    int overlap_cnt    = 0;
    int last_ready_cyc = -1;
    int last_ferr_cyc  = -1;
    int busy_rise_cyc  = -1;
    int busy_fall_cyc  = -1;
    logic busy_prev    = 1'b0;

    logic [7:0] exp_q[$];

    t10_uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .rx_serial (rx_serial),
        .rx_byte   (rx_byte),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle counter: number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    // output monitor: scoreboard pop on every rx_ready, event bookkeeping
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (rx_ready === 1'b1) begin
            ready_cnt      = ready_cnt + 1;
            last_ready_cyc = cyc;
            chk_cnt        = chk_cnt + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL rx_byte_sb: unexpected rx_ready, got %02h, expected no strobe", rx_byte);
            end else begin
                exp_b = exp_q.pop_front();
                if (rx_byte !== exp_b) begin
                    $display("FAIL rx_byte_sb: got %02h expected %02h", rx_byte, exp_b);
                end else begin
                    pass_cnt = pass_cnt + 1;
                end
            end
        end
        if (frame_err === 1'b1) begin
            ferr_cnt      = ferr_cnt + 1;
            last_ferr_cyc = cyc;
        end
        if (rx_ready === 1'b1 && frame_err === 1'b1) overlap_cnt = overlap_cnt + 1;
        if (busy === 1'b1 && busy_prev !== 1'b1) busy_rise_cyc = cyc;
        if (busy !== 1'b1 && busy_prev === 1'b1) busy_fall_cyc = cyc;
        busy_prev = busy;
    end

    // Must be called at a falling edge; returns exactly 10*C cycles later.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_serial = 1'b0;
        start_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (C) @(negedge clk);
            rx_serial = b[i];
        end
        repeat (C) @(negedge clk);
        rx_serial = stop_bit;
        repeat (C) @(negedge clk);
        rx_serial = 1'b1;
    endtask

    task automatic test_reset;
        nRst      = 1'b0;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt = chk_cnt + 1;
        if (rx_byte !== 8'h00) $display("FAIL reset_rx_byte: got %02h expected 00", rx_byte);
        else pass_cnt = pass_cnt + 1;
        chk_cnt = chk_cnt + 1;
        if ({rx_ready, frame_err, busy} !== 3'b000)
            $display("FAIL reset_strobes: got %b expected 000", {rx_ready, frame_err, busy});
        else pass_cnt = pass_cnt + 1;
        nRst = 1'b1;
        repeat (5) @(negedge clk);
        chk_cnt = chk_cnt + 1;
        if ({rx_ready, frame_err, busy} !== 3'b000)
            $display("FAIL post_reset_idle: got %b expected 000", {rx_ready, frame_err, busy});
        else pass_cnt = pass_cnt + 1;
    endtask

    task automatic test_single_frame;
        int r0, f0, d0;
        r0 = ready_cnt;
        f0 = ferr_cnt;
        @(negedge clk);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        d0 = start_cyc;
        repeat (10) @(negedge clk);
        chk_cnt = chk_cnt + 1;
        if (ready_cnt - r0 !== 1) $display("FAIL single_ready_cycles: got %0d expected 1", ready_cnt - r0);
        else pass_cnt = pass_cnt + 1;
        chk_cnt = chk_cnt + 1;
        if (last_ready_cyc !== d0 + 79)
            $display("FAIL single_ready_time: got %0d expected %0d", last_ready_cyc, d0 + 79);
        else pass_cnt = pass_cnt + 1;
        chk_cnt = chk_cnt + 1;
        if (ferr_cnt !== f0) $display("FAIL single_no_ferr: got %0d expected %0d", ferr_cnt, f0);
        else pass_cnt = pass_cnt + 1;
        chk_cnt = chk_cnt + 1;
        if (busy_rise_cyc !== d0 + 3)
            $display("FAIL single_busy_rise: got %0d expected %0d", busy_rise_cyc, d0 + 3);
        else pass_cnt = pass_cnt + 1;
        chk_cnt = chk_cnt + 1;
        if (busy_fall_cyc !== d0 + 79)
            $display("FAIL single_busy_fall: got %0d expected %0d", busy_fall_cyc, d0 + 79);
        else pass_cnt = pass_cnt + 1;
    endtask

    task automatic test_glitch;
        int r0, f0;
        r0 = ready_cnt;
        f0 = ferr_cnt;
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (2) @(negedge clk);
        rx_serial = 1'b1;
        repeat (5) @(negedge clk);
        chk_cnt = chk_cnt + 1;
        if (busy !== 1'b0) $display("FAIL glitch_busy_t5: got %b expected 0", busy);
        else pass_cnt = pass_cnt + 1;
        repeat (20) @(negedge clk);
        chk_cnt = chk_cnt + 1;
        if (ready_cnt !== r0 || ferr_cnt !== f0)
            $display("FAIL glitch_no_strobe: got ready %0d ferr %0d expected %0d %0d",
                     ready_cnt - r0, ferr_cnt - f0, 0, 0);
        else pass_cnt = pass_cnt + 1;
        chk_cnt = chk_cnt + 1;
        if (rx_byte !== 8'hA5) $display("FAIL glitch_rx_byte: got %02h expected a5", rx_byte);
        else pass_cnt = pass_cnt + 1;
    endtask

    task automatic test_framing_error;
        int r0, f0, d0;
        r0 = ready_cnt;
        f0 = ferr_cnt;
        @(negedge clk);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        send_frame(8'h81, 1'b0);
        d0 = start_cyc;
        // send_frame restores the line high; keep it low instead
        rx_serial = 1'b0;
        repeat (20) @(negedge clk);
        chk_cnt = chk_cnt + 1;
        if (busy !== 1'b1) $display("FAIL ferr_busy_held: got %b expected 1", busy);
        else pass_cnt = pass_cnt + 1;
        rx_serial = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt = chk_cnt + 1;
        if (busy !== 1'b1) $display("FAIL ferr_busy_sync: got %b expected 1", busy);
        else pass_cnt = pass_cnt + 1;
        @(negedge clk);
        chk_cnt = chk_cnt + 1;
        if (busy !== 1'b0) $display("FAIL ferr_busy_release: got %b expected 0", busy);
        else pass_cnt = pass_cnt + 1;
        repeat (5) @(negedge clk);
        chk_cnt = chk_cnt + 1;
        if (ferr_cnt - f0 !== 1) $display("FAIL ferr_pulse_count: got %0d expected 1", ferr_cnt - f0);
        else pass_cnt = pass_cnt + 1;
        chk_cnt = chk_cnt + 1;
        if (last_ferr_cyc !== d0 + 79)
            $display("FAIL ferr_time: got %0d expected %0d", last_ferr_cyc, d0 + 79);
        else pass_cnt = pass_cnt + 1;
        chk_cnt = chk_cnt + 1;
        if (ready_cnt - r0 !== 1) $display("FAIL ferr_ready_count: got %0d expected 1", ready_cnt - r0);
        else pass_cnt = pass_cnt + 1;
        chk_cnt = chk_cnt + 1;
        if (rx_byte !== 8'h3C) $display("FAIL ferr_rx_byte: got %02h expected 3c", rx_byte);
        else pass_cnt = pass_cnt + 1;
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [3];
        int r0;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h5A;
        r0 = ready_cnt;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(bytes[i]);
            send_frame(bytes[i], 1'b1);
        end
        repeat (20) @(negedge clk);
        chk_cnt = chk_cnt + 1;
        if (ready_cnt - r0 !== 3) $display("FAIL b2b_ready_count: got %0d expected 3", ready_cnt - r0);
        else pass_cnt = pass_cnt + 1;
        chk_cnt = chk_cnt + 1;
        if (exp_q.size() !== 0) $display("FAIL b2b_queue_drained: got %0d expected 0", exp_q.size());
        else pass_cnt = pass_cnt + 1;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        int r0, f0;
        b  = 8'hC3;
        r0 = ready_cnt;
        f0 = ferr_cnt;
        @(negedge clk);
        rx_serial = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (C) @(negedge clk);
            rx_serial = b[i];
        end
        repeat (3) @(negedge clk);
        #2;
        nRst = 1'b0;
        #1;
        chk_cnt = chk_cnt + 1;
        if (busy !== 1'b0 || rx_byte !== 8'h00)
            $display("FAIL midrst_async: got busy %b rx_byte %02h expected 0 00", busy, rx_byte);
        else pass_cnt = pass_cnt + 1;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        repeat (10) @(negedge clk);
        chk_cnt = chk_cnt + 1;
        if (ready_cnt !== r0 || ferr_cnt !== f0)
            $display("FAIL midrst_no_strobe: got ready %0d ferr %0d expected 0 0",
                     ready_cnt - r0, ferr_cnt - f0);
        else pass_cnt = pass_cnt + 1;
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        repeat (10) @(negedge clk);
        chk_cnt = chk_cnt + 1;
        if (ready_cnt - r0 !== 1) $display("FAIL midrst_ready_count: got %0d expected 1", ready_cnt - r0);
        else pass_cnt = pass_cnt + 1;
        chk_cnt = chk_cnt + 1;
        if (rx_byte !== 8'h12) $display("FAIL midrst_rx_byte: got %02h expected 12", rx_byte);
        else pass_cnt = pass_cnt + 1;
    endtask

    task automatic test_strobe_exclusive;
        chk_cnt = chk_cnt + 1;
        if (overlap_cnt !== 0) $display("FAIL strobe_overlap: got %0d expected 0", overlap_cnt);
        else pass_cnt = pass_cnt + 1;
        chk_cnt = chk_cnt + 1;
        if (exp_q.size() !== 0) $display("FAIL sb_leftover: got %0d expected 0", exp_q.size());
        else pass_cnt = pass_cnt + 1;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_strobe_exclusive();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
